forward_operand_unit: RTL and testbench
=======================================

// Module: forward_operand_unit
// PURPOSE
//  Parametrised successor to the 3-input forwarding mux. For each decoded instruction it
//  resolves both source operands from NUM_SRC in-flight pipeline stages (youngest first) or
//  the register file, detects not-yet-available producers (load-use), stalls decode and
//  registers the operands into an EX-side valid/ready output slot. Sits between ID and EX.
// PARAMETERS
//  WIDTH      32  operand data width
//  NUM_SRC    3   forwarding sources; index 0 = youngest stage (EX/MEM), NUM_SRC-1 = oldest (WB)
//  AW         5   register address width
//  MAX_STALL  8   consecutive hazard cycles before stall_err is raised
//  CNT_W      16  perf counter width (FWD_PERF_CNT_EN only)
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            synchronous reset, active-high
//  id_valid     in   1            decode presents an instruction
//  id_rs1       in   AW           source register A
//  id_rs2       in   AW           source register B
//  rf_rd1       in   WIDTH        register file read data for rs1
//  rf_rd2       in   WIDTH        register file read data for rs2
//  src_we       in   NUM_SRC      source i writes a register
//  src_rd       in   NUM_SRC*AW   destination of source i (slice i)
//  src_data     in   NUM_SRC*WIDTH result of source i (slice i)
//  src_pending  in   NUM_SRC      source i result not yet available (e.g. load in flight)
//  ex_ready     in   1            EX accepts the output slot
//  id_stall     out  1            decode must hold its instruction this cycle
//  op_valid     out  1            output slot holds operands
//  op_a, op_b   out  WIDTH        registered resolved operands
//  sel_a, sel_b out  $clog2(NUM_SRC+1)  registered choice: 0 = regfile, i+1 = source i
//  stall_err    out  1            sticky: hazard exceeded MAX_STALL cycles
// BEHAVIOUR
//  - Reset: op_valid=0, op_a=op_b=0, sel_a=sel_b=0, stall_err=0, stall counter=0, state=IDLE.
//  - Match for rsX: src_we[i] && src_rd[i]==rsX && rsX!=0. Lowest matching i wins.
//  - rsX==0: operand forced to 0, sel=0, never forwarded, never a hazard.
//  - hazard = id_valid && winning match (per operand) has src_pending set; an older
//    non-pending match never overrides a younger pending one.
//  - Slot loads when id_valid && !hazard && (!op_valid || ex_ready); latency 1 cycle
//    (resolve in cycle N, op_* valid in N+1). Transfer when op_valid && ex_ready.
//  - Same-cycle transfer+load: slot replaced, op_valid stays 1. Transfer without load: op_valid->0.
//  - id_stall = id_valid && (hazard || (op_valid && !ex_ready)) (combinational).
//  - FSM: IDLE (slot empty), FULL (slot valid), STALL (hazard on presented instr).
//    IDLE->FULL on load; IDLE/FULL->STALL on hazard; STALL->FULL when hazard clears;
//    FULL->IDLE on transfer without load; any state -> IDLE on rst.
//  - STALL counter: +1 per hazard cycle, cleared when hazard clears; reaching MAX_STALL sets
//    stall_err (cleared only by rst). Counter saturates at MAX_STALL.
//  - Reset asserted mid-transfer drops the slot; no partial operand is emitted.
// CONFIGURATION
//  FWD_PERF_CNT_EN defined: extra outputs fwd_cnt, stall_cnt (CNT_W each), reset 0;
//  fwd_cnt += number of operands with sel!=0 on each load (0..2), stall_cnt += 1 per
//  id_stall cycle; both saturate at all-ones. Undefined: ports and counters absent.
// STRUCTURE
//  Package fwd_pkg: fwd_state_t enum {IDLE, FULL, STALL}; function sel_w(NUM_SRC);
//  SEL_RF constant = 0.
//  Sub-module fwd_select (combinational, instantiated twice): rs, src_* , rf data ->
//  operand, sel, pending flag via priority encoder.
// TESTING
//  1 No match: rs1=3, rs2=4, no src_we -> next cycle op_a=rf_rd1, op_b=rf_rd2, sel=0/0.
//  2 Priority: src0 and src2 both write x5 (0xAAAA/0xBBBB), rs1=5 -> op_a=0xAAAA, sel_a=1.
//  3 x0: src0 writes x0 with 0x1234, rs1=0 -> op_a=0, sel_a=0, id_stall=0.
//  4 Load-use: src_pending[0]=1 on rd=7, rs2=7 for 2 cycles -> id_stall=1 two cycles,
//    then op_b=src_data[0], op_valid=1 one cycle after pending drops.
//  5 Backpressure: ex_ready=0 with slot full -> id_stall=1, op_* stable; ex_ready=1 with
//    id_valid -> slot replaced same cycle, op_valid stays 1.
//  6 Timeout/reset: pending held 8 cycles -> stall_err=1 and stays; rst -> all outputs 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and helpers for the operand forwarding unit
package fwd_pkg;
    typedef enum logic [1:0] {IDLE, FULL, STALL} fwd_state_t;
    localparam int SEL_RF = 0;
    function automatic int sel_w(input int num_src);
        return $clog2(num_src + 1);
    endfunction
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority-resolves one source operand from in-flight stages or the register file
module fwd_select
    import fwd_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3,
    parameter int AW      = 5,
    localparam int SW     = sel_w(NUM_SRC)
) (
    input  logic [AW-1:0]            rs,
    input  logic [NUM_SRC-1:0]       src_we,
    input  logic [NUM_SRC*AW-1:0]    src_rd,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_pending,
    input  logic [WIDTH-1:0]         rf_data,
    output logic [WIDTH-1:0]         operand,
    output logic [SW-1:0]            sel,
    output logic                     pending
);
    // walk oldest to youngest so the youngest match is assigned last and wins
    always_comb begin
        operand = (rs == '0) ? '0 : rf_data;
        sel     = SW'(SEL_RF);
        pending = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (src_we[i] && src_rd[i*AW +: AW] == rs && rs != '0) begin
                operand = src_data[i*WIDTH +: WIDTH];
                sel     = SW'(i + 1);
                pending = src_pending[i];
            end
    end
endmodule

// File: rtl/forward_operand_unit.sv
// forward_operand_unit: ID->EX operand forwarding with load-use stall and output slot
// Optional perf counters fwd_cnt/stall_cnt enabled by defining FWD_PERF_CNT_EN.
module forward_operand_unit
    import fwd_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_SRC   = 3,
    parameter int AW        = 5,
    parameter int MAX_STALL = 8,
`ifdef FWD_PERF_CNT_EN
    parameter int CNT_W     = 16,
`endif
    localparam int SW       = sel_w(NUM_SRC),
    localparam int CW       = $clog2(MAX_STALL + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [AW-1:0]            id_rs1,
    input  logic [AW-1:0]            id_rs2,
    input  logic [WIDTH-1:0]         rf_rd1,
    input  logic [WIDTH-1:0]         rf_rd2,
    input  logic [NUM_SRC-1:0]       src_we,
    input  logic [NUM_SRC*AW-1:0]    src_rd,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_pending,
    input  logic                     ex_ready,
    output logic                     id_stall,
    output logic                     op_valid,
    output logic [WIDTH-1:0]         op_a,
    output logic [WIDTH-1:0]         op_b,
    output logic [SW-1:0]            sel_a,
    output logic [SW-1:0]            sel_b,
    output logic                     stall_err
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]         fwd_cnt,
    output logic [CNT_W-1:0]         stall_cnt
`endif
);
    fwd_state_t state;
    logic [CW-1:0] stall_ctr;
    logic [WIDTH-1:0] res_a, res_b;
    logic [SW-1:0] rsel_a, rsel_b;
    logic pend_a, pend_b, hazard, load, xfer;

    fwd_select #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .AW(AW)) u_sel_a (
        .rs(id_rs1), .src_we(src_we), .src_rd(src_rd), .src_data(src_data),
        .src_pending(src_pending), .rf_data(rf_rd1), .operand(res_a), .sel(rsel_a), .pending(pend_a)
    );
    fwd_select #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .AW(AW)) u_sel_b (
        .rs(id_rs2), .src_we(src_we), .src_rd(src_rd), .src_data(src_data),
        .src_pending(src_pending), .rf_data(rf_rd2), .operand(res_b), .sel(rsel_b), .pending(pend_b)
    );

    assign hazard   = id_valid && (pend_a || pend_b);
    assign xfer     = op_valid && ex_ready;
    assign load     = id_valid && !hazard && (!op_valid || ex_ready);
    assign id_stall = id_valid && (hazard || (op_valid && !ex_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_valid  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            sel_a     <= '0;
            sel_b     <= '0;
            stall_ctr <= '0;
            stall_err <= 1'b0;
        end else begin
            state     <= hazard ? STALL : load ? FULL :
                         (state != IDLE && op_valid && !xfer) ? FULL : IDLE;
            op_valid  <= load || (op_valid && !xfer);
            if (load) begin
                op_a  <= res_a;
                op_b  <= res_b;
                sel_a <= rsel_a;
                sel_b <= rsel_b;
            end
            stall_ctr <= !hazard ? '0 : (stall_ctr == CW'(MAX_STALL)) ? stall_ctr : stall_ctr + 1'b1;
            stall_err <= stall_err || (hazard && stall_ctr >= CW'(MAX_STALL - 1));
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [1:0] fwd_inc;
    logic [CNT_W:0] fwd_sum, stall_sum;
    always_comb begin
        fwd_inc   = load ? {1'b0, rsel_a != '0} + {1'b0, rsel_b != '0} : 2'd0;
        fwd_sum   = {1'b0, fwd_cnt} + (CNT_W+1)'(fwd_inc);
        stall_sum = {1'b0, stall_cnt} + (CNT_W+1)'(id_stall);
    end
    // carry out of the extended sum means the counter would wrap, so pin at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            fwd_cnt   <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
            stall_cnt <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
        end
    end
`endif
endmodule

// File: tb/tb_forward_operand_unit.sv
// tb_forward_operand_unit: directed self-checking bench for forward_operand_unit
module tb_forward_operand_unit;
    localparam int WIDTH = 32, NUM_SRC = 3, AW = 5;

    logic clk = 1'b0;
    logic rst, id_valid, ex_ready;
    logic [AW-1:0] id_rs1, id_rs2;
    logic [WIDTH-1:0] rf_rd1, rf_rd2;
    logic [NUM_SRC-1:0] src_we, src_pending;
    logic [AW-1:0] rd [NUM_SRC];
    logic [WIDTH-1:0] dat [NUM_SRC];
    logic [NUM_SRC*AW-1:0] src_rd;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic id_stall, op_valid, stall_err;
    logic [WIDTH-1:0] op_a, op_b;
    logic [1:0] sel_a, sel_b;
`ifdef FWD_PERF_CNT_EN
    logic [15:0] fwd_cnt, stall_cnt;
`endif
    int checks = 0;
    int errors = 0;

    assign src_rd   = {rd[2], rd[1], rd[0]};
    assign src_data = {dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    forward_operand_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .src_we(src_we), .src_rd(src_rd),
        .src_data(src_data), .src_pending(src_pending), .ex_ready(ex_ready),
        .id_stall(id_stall), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
        .sel_a(sel_a), .sel_b(sel_b), .stall_err(stall_err)
`ifdef FWD_PERF_CNT_EN
        , .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_src();
        src_we = '0;
        src_pending = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rd[i] = '0;
            dat[i] = '0;
        end
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; ex_ready = 1'b1;
        id_rs1 = '0; id_rs2 = '0; rf_rd1 = 32'h1111_1111; rf_rd2 = 32'h2222_2222;
        clr_src();
        step(); step();
        rst = 1'b0;
        chk("rst_valid", op_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_sel_a", sel_a, 0);
        chk("rst_err", stall_err, 0);

        // no match: regfile data
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd4;
        #1 chk("nm_stall", id_stall, 0);
        step();
        chk("nm_valid", op_valid, 1);
        chk("nm_op_a", op_a, 32'h1111_1111);
        chk("nm_op_b", op_b, 32'h2222_2222);
        chk("nm_sel_a", sel_a, 0);
        chk("nm_sel_b", sel_b, 0);

        // youngest match wins; src1 forwards to rs2
        id_rs1 = 5'd5;
        src_we = 3'b111;
        rd[0] = 5'd5; dat[0] = 32'hAAAA;
        rd[1] = 5'd4; dat[1] = 32'hCCCC;
        rd[2] = 5'd5; dat[2] = 32'hBBBB;
        step();
        chk("pri_valid", op_valid, 1);
        chk("pri_op_a", op_a, 32'hAAAA);
        chk("pri_sel_a", sel_a, 1);
        chk("pri_op_b", op_b, 32'hCCCC);
        chk("pri_sel_b", sel_b, 2);

        // x0 never forwarded
        clr_src();
        src_we = 3'b001; rd[0] = 5'd0; dat[0] = 32'h1234;
        id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1 chk("x0_stall", id_stall, 0);
        step();
        chk("x0_op_a", op_a, 0);
        chk("x0_sel_a", sel_a, 0);
        chk("x0_op_b", op_b, 0);

        // load-use: young pending match beats older ready match
        clr_src();
        src_we = 3'b101; src_pending = 3'b001;
        rd[0] = 5'd7; dat[0] = 32'h77;
        rd[2] = 5'd7; dat[2] = 32'h99;
        id_rs1 = 5'd3; id_rs2 = 5'd7;
        #1 chk("lu_stall1", id_stall, 1);
        step();
        chk("lu_drain", op_valid, 0);
        chk("lu_stall2", id_stall, 1);
        step();
        src_pending = '0;
        #1 chk("lu_clear", id_stall, 0);
        step();
        chk("lu_valid", op_valid, 1);
        chk("lu_op_b", op_b, 32'h77);
        chk("lu_sel_b", sel_b, 1);
        chk("lu_op_a", op_a, 32'h1111_1111);

        // backpressure holds slot, then same-cycle replace
        clr_src();
        ex_ready = 1'b0; id_rs1 = 5'd3; id_rs2 = 5'd4;
        #1 chk("bp_stall", id_stall, 1);
        step();
        chk("bp_hold_b", op_b, 32'h77);
        chk("bp_hold_v", op_valid, 1);
        ex_ready = 1'b1;
        #1 chk("bp_go", id_stall, 0);
        step();
        chk("bp_repl_v", op_valid, 1);
        chk("bp_repl_b", op_b, 32'h2222_2222);
        chk("bp_repl_sel", sel_b, 0);
        id_valid = 1'b0;
        step();
        chk("bp_empty", op_valid, 0);

        // timeout: 8 hazard cycles raise sticky stall_err
        id_valid = 1'b1; id_rs2 = 5'd7;
        src_we = 3'b001; src_pending = 3'b001; rd[0] = 5'd7;
        repeat (7) step();
        chk("to_err7", stall_err, 0);
        step();
        chk("to_err8", stall_err, 1);
        clr_src();
        id_valid = 1'b0;
        step();
        chk("to_sticky", stall_err, 1);
        id_valid = 1'b1; id_rs2 = 5'd4;
        step();
        chk("to_load", op_valid, 1);

        // reset while transferring drops the slot
        rst = 1'b1;
        step();
        rst = 1'b0; id_valid = 1'b0;
        chk("rr_valid", op_valid, 0);
        chk("rr_op_a", op_a, 0);
        chk("rr_op_b", op_b, 0);
        chk("rr_sel_b", sel_b, 0);
        chk("rr_err", stall_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
